// File: rtl/codec_cfg_sequencer_if.sv
// Host-request and i2cc handshake bundle for the WM8731 configuration sequencer.
// Handshakes:
//   host: host_req is a level held until host_ack; host_ack pulses for one cycle
//         and host_nack is valid only in that cycle. The requester drops
//         host_req the cycle after host_ack.
//   i2cc: i2c_start pulses for one cycle, only while i2c_busy=0; i2c_data is held
//         from start until i2c_done; i2c_nack is valid only while i2c_done=1.
interface codec_cfg_sequencer_if;
  logic        host_req;
  logic [6:0]  host_reg_addr;
  logic [8:0]  host_reg_data;
  logic        host_ack;
  logic        host_nack;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_nack;

  modport master (
    input  host_req, host_reg_addr, host_reg_data, i2c_busy, i2c_done, i2c_nack,
    output host_ack, host_nack, i2c_start, i2c_data
  );

  modport slave (
    output host_req, host_reg_addr, host_reg_data, i2c_busy, i2c_done, i2c_nack,
    input  host_ack, host_nack, i2c_start, i2c_data
  );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// Drives the i2cc that configures the WM8731: writes the power-up register table,
// retries NACKed frames, then serves single-register host writes.
module codec_cfg_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter logic [15:0] PWR_WAIT   = 16'd50000,
  parameter logic [7:0]  GAP_CYCLES = 8'd100,
  parameter logic [1:0]  MAX_RETRY  = 2'd3
) (
  input  logic                         clk,
  input  logic                         reset,
  codec_cfg_sequencer_if.master        bus,
  output logic                         init_done,
  output logic                         cfg_error,
  output logic                         busy,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_READY = 3'd5
  } state_t;

  state_t      state_q, state_d;
  state_t      after_q, after_d;
  logic [3:0]  index_q, index_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] cnt_q, cnt_d;
  logic        host_phase_q, host_phase_d;
  logic [6:0]  host_addr_q, host_addr_d;
  logic [8:0]  host_data_q, host_data_d;
  logic        i2c_start_q, i2c_start_d;
  logic [23:0] i2c_data_q, i2c_data_d;
  logic        host_ack_q, host_ack_d;
  logic        host_nack_q, host_nack_d;
  logic        init_done_q, init_done_d;
  logic        cfg_error_q, cfg_error_d;
  logic        busy_q, busy_d;

  // Power-up table as {reg_addr[6:0], reg_data[8:0]}.
  function automatic logic [15:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    init_entry = {7'd15, 9'h000};
      4'd1:    init_entry = {7'd0,  9'h017};
      4'd2:    init_entry = {7'd1,  9'h017};
      4'd3:    init_entry = {7'd2,  9'h079};
      4'd4:    init_entry = {7'd3,  9'h079};
      4'd5:    init_entry = {7'd4,  9'h012};
      4'd6:    init_entry = {7'd5,  9'h000};
      4'd7:    init_entry = {7'd6,  9'h000};
      4'd8:    init_entry = {7'd7,  9'h042};
      4'd9:    init_entry = {7'd9,  9'h001};
      default: init_entry = 16'h0000;
    endcase
  endfunction

  always_comb begin
    logic        advance;
    logic        abandon;
    logic [15:0] cnt_nxt;
    advance      = 1'b0;
    abandon      = 1'b0;
    cnt_nxt      = cnt_q + 16'd1;
    state_d      = state_q;
    after_d      = after_q;
    index_d      = index_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    host_phase_d = host_phase_q;
    host_addr_d  = host_addr_q;
    host_data_d  = host_data_q;
    i2c_start_d  = 1'b0;
    i2c_data_d   = i2c_data_q;
    host_ack_d   = 1'b0;
    host_nack_d  = 1'b0;
    init_done_d  = init_done_q;
    cfg_error_d  = cfg_error_q;

    case (state_q)
      S_PWR: begin
        if (cnt_nxt >= PWR_WAIT) begin
          cnt_d   = 16'd0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      S_LOAD: begin
        i2c_data_d = host_phase_q ? {DEV_ADDR, 1'b0, host_addr_q, host_data_q}
                                  : {DEV_ADDR, 1'b0, init_entry(index_q)};
        state_d    = S_START;
      end
      S_START: begin
        if (!bus.i2c_busy) begin
          i2c_start_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
            retry_d = 2'd0;
            advance = 1'b1;
          end else if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 2'd1;
            cnt_d   = 16'd0;
            after_d = S_START;
            state_d = S_GAP;
          end else begin
            cfg_error_d = 1'b1;
            retry_d     = 2'd0;
            advance     = 1'b1;
            abandon     = 1'b1;
          end
          if (advance) begin
            cnt_d   = 16'd0;
            state_d = S_GAP;
            if (host_phase_q) begin
              host_ack_d  = 1'b1;
              host_nack_d = abandon;
              after_d     = S_READY;
            end else if (index_q == 4'd9) begin
              init_done_d = 1'b1;
              after_d     = S_READY;
            end else begin
              index_d = index_q + 4'd1;
              after_d = S_LOAD;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_nxt >= {8'd0, GAP_CYCLES}) begin
          cnt_d   = 16'd0;
          state_d = after_q;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      S_READY: begin
        if (bus.host_req) begin
          host_addr_d  = bus.host_reg_addr;
          host_data_d  = bus.host_reg_data;
          host_phase_d = 1'b1;
          state_d      = S_LOAD;
        end
      end
      default: state_d = S_PWR;
    endcase

    busy_d = (state_d != S_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_PWR;
      after_q      <= S_LOAD;
      index_q      <= 4'd0;
      retry_q      <= 2'd0;
      cnt_q        <= 16'd0;
      host_phase_q <= 1'b0;
      host_addr_q  <= 7'd0;
      host_data_q  <= 9'd0;
      i2c_start_q  <= 1'b0;
      i2c_data_q   <= 24'd0;
      host_ack_q   <= 1'b0;
      host_nack_q  <= 1'b0;
      init_done_q  <= 1'b0;
      cfg_error_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      after_q      <= after_d;
      index_q      <= index_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      host_phase_q <= host_phase_d;
      host_addr_q  <= host_addr_d;
      host_data_q  <= host_data_d;
      i2c_start_q  <= i2c_start_d;
      i2c_data_q   <= i2c_data_d;
      host_ack_q   <= host_ack_d;
      host_nack_q  <= host_nack_d;
      init_done_q  <= init_done_d;
      cfg_error_q  <= cfg_error_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.i2c_start = i2c_start_q;
  assign bus.i2c_data  = i2c_data_q;
  assign bus.host_ack  = host_ack_q;
  assign bus.host_nack = host_nack_q;
  assign init_done     = init_done_q;
  assign cfg_error     = cfg_error_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Sequences the I2C controller (i2cc) that configures the WM8731 codec.
- After reset, it writes a fixed 10-entry power-up register table as 24-bit I2C frames, retrying NACKed frames.
- Once initialisation is complete, it serves single-register write requests from the Avalon host side.
- It sits between the codec_avalon register interface and the i2cc instance inside the controller.

Parameters:
- DEV_ADDR, 7'h1A: WM8731 7-bit device address. The write address byte is {DEV_ADDR,1'b0} = 8'h34.
- PWR_WAIT, 16'd50000: clk cycles to wait after reset before the first frame.
- GAP_CYCLES, 8'd100: idle clk cycles between the end of one frame and the next i2c_start (bus free time).
- MAX_RETRY, 2'd3: re-sends allowed for a NACKed frame before it is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- host_req  in  1  host write request (level); held until host_ack
- host_reg_addr  in  7  WM8731 register address
- host_reg_data  in  9  WM8731 register data
- host_ack  out  1  one-cycle pulse when the host frame finishes
- host_nack  out  1  valid with host_ack; 1 = frame abandoned after retries
- i2c_start  out  1  one-cycle start pulse to i2cc
- i2c_data  out  24  frame {DEV_ADDR,1'b0,reg_addr[6:0],reg_data[8:0]}; stable from start until done
- i2c_busy  in  1  i2cc transfer in progress
- i2c_done  in  1  one-cycle pulse at end of transfer (after STOP)
- i2c_nack  in  1  valid with i2c_done; 1 = any of the 3 ACK slots not acknowledged
- init_done  out  1  sticky; 1 after the last table entry completes
- cfg_error  out  1  sticky; 1 if any frame (init or host) was abandoned
- busy  out  1  1 in every state except READY

Behaviour:
- Reset (async, active-high) values: state=PWR, index=0, retry=0, i2c_start=0, i2c_data=0, host_ack=0, host_nack=0, init_done=0, cfg_error=0, busy=1.
- Reset mid-frame aborts immediately. The table restarts from entry 0 after PWR_WAIT. i2cc is reset by the same signal.
- Init table, index 0..9:
  - 0: R15 = 0x000 (24'h341E00)
  - 1: R0 = 0x017
  - 2: R1 = 0x017
  - 3: R2 = 0x079
  - 4: R3 = 0x079
  - 5: R4 = 0x012
  - 6: R5 = 0x000
  - 7: R6 = 0x000
  - 8: R7 = 0x042 (24'h340E42)
  - 9: R9 = 0x001 (24'h341201)
- State PWR: count PWR_WAIT cycles, then go to LOAD.
- State LOAD: drive i2c_data from the table entry (init phase) or from latched host fields (host phase), then go to START.
- State START: wait while i2c_busy=1. When i2c_busy=0, assert i2c_start for exactly 1 cycle and go to WAIT. i2c_start is never asserted while i2c_busy=1.
- State WAIT: hold i2c_data until i2c_done=1, sampling i2c_nack in that same cycle. i2c_done in any other state is ignored.
  - nack=0: clear retry, advance.
  - nack=1 and retry<MAX_RETRY: retry+1, then GAP, then START with the same frame.
  - nack=1 and retry==MAX_RETRY: set cfg_error, clear retry, advance (frame abandoned).
- Advance:
  - Init phase, index<9: index+1, GAP, LOAD.
  - Init phase, index==9: set init_done, GAP, READY.
  - Host phase: pulse host_ack=1 for 1 cycle (host_nack=1 if abandoned), then GAP, then READY.
- State GAP: count GAP_CYCLES, then go to the pending next state.
- State READY: busy=0.
  - If host_req=1, latch host_reg_addr/host_reg_data and go to LOAD.
  - host_req during init is not accepted; it stays pending and is served on entry to READY.
  - host_req must drop the cycle after host_ack. A req still high after the GAP is treated as a new request.
- Frame transfers: 1 per frame; worst case MAX_RETRY+1 per frame.
- i2c_start to host_ack latency: transfer time + 1 cycle.

Test Plan:
- Reset, i2cc model ACKs all -> exactly 10 i2c_start pulses.
  - First frame 24'h341E00, last frame 24'h341201.
  - First start no earlier than PWR_WAIT cycles after reset release.
  - Consecutive frames separated by at least GAP_CYCLES.
  - init_done=1, cfg_error=0, busy=0.
- Model NACKs frame index 3 twice, then ACKs -> frame 24'h340479 sent 3 times, cfg_error=0, 10 distinct frames, init_done=1.
- Model NACKs frame index 5 always -> frame 24'h340812 sent 4 times, then frame index 6 follows; cfg_error=1, init_done=1.
- host_req with addr 7'h04 and data 9'h015 asserted during init -> held off until READY.
  - Then frame 24'h340815.
  - host_ack one-cycle pulse with host_nack=0.
  - busy back to 0.
- reset asserted during frame index 4 -> outputs return to reset values asynchronously; after release the table replays from 24'h341E00.
- i2c_busy forced to 1 while in START -> no i2c_start until i2c_busy=0, then exactly one pulse. A spurious i2c_done in READY or GAP -> ignored, no state change.
